rvb_issue: RTL and testbench

Request-side initiator for the bitmanip execution units (rvb_shifter and siblings). Accepts decoded instructions with operands and a tag from the core, drives the unit's din_* valid/ready interface, consumes dout_* results, and returns each result to the core tagged and in order. It is the counterpart of the units' responder ports and replaces bench-style stimulus with synthesizable issue/return logic.

---
 rtl/rvb_issue_if.sv | 59 +++++
 rtl/rvb_issue.sv | 186 ++++++++++++++++++
 tb/tb_rvb_issue.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rvb_issue_if.sv
// Core-side request/response and unit-side din/dout handshakes for rvb_issue.
// The master modport is the issue block; the slave modport is the core plus the execution unit.
interface rvb_issue_if #(
  parameter int XLEN = 32,
  parameter int TAGW = 4
);
  logic            req_valid;
  logic            req_ready;
  logic [31:0]     req_insn;
  logic [XLEN-1:0] req_rs1;
  logic [XLEN-1:0] req_rs2;
  logic [XLEN-1:0] req_rs3;
  logic [TAGW-1:0] req_tag;

  logic            din_valid;
  logic            din_ready;
  logic [XLEN-1:0] din_rs1;
  logic [XLEN-1:0] din_rs2;
  logic [XLEN-1:0] din_rs3;
  logic            din_insn3;
  logic            din_insn14;
  logic            din_insn26;
  logic            din_insn27;
  logic            din_insn29;
  logic            din_insn30;

  logic            dout_valid;
  logic            dout_ready;
  logic [XLEN-1:0] dout_rd;

  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rsp_rd;
  logic [TAGW-1:0] rsp_tag;

  modport master (
    input  req_valid, req_insn, req_rs1, req_rs2, req_rs3, req_tag,
    output req_ready,
    output din_valid, din_rs1, din_rs2, din_rs3,
    output din_insn3, din_insn14, din_insn26, din_insn27, din_insn29, din_insn30,
    input  din_ready,
    input  dout_valid, dout_rd,
    output dout_ready,
    output rsp_valid, rsp_rd, rsp_tag,
    input  rsp_ready
  );

  modport slave (
    output req_valid, req_insn, req_rs1, req_rs2, req_rs3, req_tag,
    input  req_ready,
    input  din_valid, din_rs1, din_rs2, din_rs3,
    input  din_insn3, din_insn14, din_insn26, din_insn27, din_insn29, din_insn30,
    output din_ready,
    output dout_valid, dout_rd,
    input  dout_ready,
    input  rsp_valid, rsp_rd, rsp_tag,
    output rsp_ready
  );
endinterface

// File: rtl/rvb_issue.sv
// rvb_issue: in-order issue/return initiator for the bitmanip execution units.
// Defining RVB_ISSUE_TIMEOUT_EN adds a watchdog on results outstanding for TMO_CYC cycles.
module rvb_issue #(
  parameter int XLEN    = 32,
  parameter int TAGW    = 4,
  parameter int MAX_OUT = 4,
  parameter int TMO_CYC = 255
) (
  input  logic        clock_i,
  input  logic        resetn_i,
  rvb_issue_if.master bus,
  output logic        err_o
);

  localparam int PW = $clog2(MAX_OUT);
  localparam int CW = $clog2(MAX_OUT + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(MAX_OUT);

  // issue register; ib packs insn bits {30,29,27,26,14,3}
  logic            iv_q, iv_d;
  logic [5:0]      ib_q, ib_d;
  logic [XLEN-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rs3_q, rs3_d;
  logic [TAGW-1:0] tag_q, tag_d;

  logic [TAGW-1:0] tagq_mem_q [MAX_OUT];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            rsp_valid_q, rsp_valid_d;
  logic [XLEN-1:0] rsp_rd_q, rsp_rd_d;
  logic [TAGW-1:0] rsp_tag_q, rsp_tag_d;
  logic            err_q, err_d;

  logic tagq_full, tagq_empty;
  logic din_valid, din_fire, req_ready, req_fire;
  logic dout_ready, dout_hs, cap, drop, tmo_hit;

  assign tagq_full  = (cnt_q == CNT_FULL);
  assign tagq_empty = (cnt_q == '0);
  assign din_valid  = iv_q && !tagq_full;
  assign din_fire   = din_valid && bus.din_ready;
  assign req_ready  = !iv_q || din_fire;
  assign req_fire   = bus.req_valid && req_ready;
  assign dout_ready = tagq_empty || !rsp_valid_q || bus.rsp_ready;
  assign dout_hs    = bus.dout_valid && dout_ready;
  assign cap        = dout_hs && !tagq_empty;
  assign drop       = bus.dout_valid && tagq_empty;

  always_comb begin
    iv_d  = iv_q;
    ib_d  = ib_q;
    rs1_d = rs1_q;
    rs2_d = rs2_q;
    rs3_d = rs3_q;
    tag_d = tag_q;
    if (din_fire) iv_d = 1'b0;
    if (req_fire) begin
      iv_d  = 1'b1;
      ib_d  = {bus.req_insn[30], bus.req_insn[29], bus.req_insn[27],
               bus.req_insn[26], bus.req_insn[14], bus.req_insn[3]};
      rs1_d = bus.req_rs1;
      rs2_d = bus.req_rs2;
      rs3_d = bus.req_rs3;
      tag_d = bus.req_tag;
    end
  end

  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      iv_q  <= 1'b0;
      ib_q  <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
      rs3_q <= '0;
      tag_q <= '0;
    end else begin
      iv_q  <= iv_d;
      ib_q  <= ib_d;
      rs1_q <= rs1_d;
      rs2_q <= rs2_d;
      rs3_q <= rs3_d;
      tag_q <= tag_d;
    end
  end

  assign bus.req_ready  = req_ready;
  assign bus.din_valid  = din_valid;
  assign bus.din_rs1    = rs1_q;
  assign bus.din_rs2    = rs2_q;
  assign bus.din_rs3    = rs3_q;
  assign bus.din_insn30 = ib_q[5];
  assign bus.din_insn29 = ib_q[4];
  assign bus.din_insn27 = ib_q[3];
  assign bus.din_insn26 = ib_q[2];
  assign bus.din_insn14 = ib_q[1];
  assign bus.din_insn3  = (XLEN == 64) ? ib_q[0] : 1'b0;

  // pointers wrap naturally because MAX_OUT is a power of two
  always_comb begin
    wr_ptr_d = din_fire ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = cap ? rd_ptr_q + PW'(1) : rd_ptr_q;
    cnt_d    = cnt_q;
    case ({din_fire, cap})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (din_fire) tagq_mem_q[wr_ptr_q] <= tag_q;
  end

  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

`ifdef RVB_ISSUE_TIMEOUT_EN
  localparam int TW = $clog2(TMO_CYC + 1);
  localparam logic [TW-1:0] TMO_INIT = TW'(TMO_CYC);

  logic [TW-1:0] tmo_q, tmo_d;

  // down-counter reloads whenever nothing is owed or a result arrives
  always_comb begin
    tmo_d   = tmo_q;
    tmo_hit = 1'b0;
    if (tagq_empty || dout_hs) begin
      tmo_d = TMO_INIT;
    end else if (tmo_q != '0) begin
      tmo_d   = tmo_q - TW'(1);
      tmo_hit = (tmo_q == TW'(1));
    end
  end

  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) tmo_q <= TMO_INIT;
    else           tmo_q <= tmo_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_rd_d    = rsp_rd_q;
    rsp_tag_d   = rsp_tag_q;
    if (cap) begin
      rsp_valid_d = 1'b1;
      rsp_rd_d    = bus.dout_rd;
      rsp_tag_d   = tagq_mem_q[rd_ptr_q];
    end else if (bus.rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
    err_d = err_q || drop || tmo_hit;
  end

  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      rsp_valid_q <= 1'b0;
      rsp_rd_q    <= '0;
      rsp_tag_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_rd_q    <= rsp_rd_d;
      rsp_tag_q   <= rsp_tag_d;
      err_q       <= err_d;
    end
  end

  assign bus.dout_ready = dout_ready;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_rd     = rsp_rd_q;
  assign bus.rsp_tag    = rsp_tag_q;
  assign err_o          = err_q;

endmodule

// File: tb/tb_rvb_issue.sv
// Scoreboard bench for rvb_issue with a behavioural shifter stub standing in for the unit.
module tb_rvb_issue;
  localparam int XLEN    = 32;
  localparam int TAGW    = 4;
  localparam int MAX_OUT = 4;
  localparam int TMO     = 10;
  localparam int NS      = 320;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic err;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rvb_issue_if #(.XLEN(XLEN), .TAGW(TAGW)) bus();

  rvb_issue #(.XLEN(XLEN), .TAGW(TAGW), .MAX_OUT(MAX_OUT), .TMO_CYC(TMO)) dut (
    .clock_i (clk),
    .resetn_i(rst_n),
    .bus     (bus),
    .err_o   (err)
  );

  typedef struct { logic [TAGW-1:0] tag; logic [XLEN-1:0] rd; } exp_t;
  typedef struct { logic [XLEN-1:0] rd; int rdy; } uop_t;
  exp_t sb[$];
  uop_t uq[$];

  int checks = 0, errors = 0;
  int nbeats = 0, mark = 0, first_cyc = 0, last_cyc = 0;
  int stalls = 0;
  bit mon_rdy = 1'b1, stub_hold = 1'b0, stub_bogus = 1'b0, bp_done = 1'b0;

  // directed vectors: ror/rol from the shifter, xor3 for everything else
  logic [31:0] v_insn [8] = '{32'h60005033, 32'h60001033, 32'h60005033, 32'h60001033,
                              32'h60005033, 32'h60001033, 32'h00004033, 32'h00004033};
  logic [31:0] v_rs1  [8] = '{32'h00000001, 32'h80000000, 32'h12345678, 32'h12345678,
                              32'hF0000000, 32'hA5A5A5A5, 32'hFF00FF00, 32'h11111111};
  logic [31:0] v_rs2  [8] = '{32'h00000001, 32'h00000001, 32'h00000008, 32'h00000004,
                              32'h00000024, 32'h00000000, 32'h0F0F0F0F, 32'h22222222};
  logic [31:0] v_rs3  [8] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h44444444};
  logic [31:0] v_exp  [8] = '{32'h80000000, 32'h00000001, 32'h78123456, 32'h23456781,
                              32'h0F000000, 32'hA5A5A5A5, 32'hF00FF00F, 32'h77777777};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] unit_fn(input logic i30, input logic i29, input logic i14,
                                          input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] c);
    logic [5:0] sh;
    sh = {1'b0, b[4:0]};
    if (i30 && i29) begin
      if (i14) return (a >> sh) | (a << (6'd32 - sh));
      else     return (a << sh) | (a >> (6'd32 - sh));
    end
    return a ^ b ^ c;
  endfunction

  task automatic issue(input int idx, input logic [TAGW-1:0] tag);
    int   tries = 0;
    bit   done = 1'b0;
    exp_t e;
    while (!done) begin
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_insn  = v_insn[idx];
      bus.req_rs1   = v_rs1[idx];
      bus.req_rs2   = v_rs2[idx];
      bus.req_rs3   = v_rs3[idx];
      bus.req_tag   = tag;
      #1;
      if (bus.req_ready) begin
        e.tag = tag;
        e.rd  = v_exp[idx];
        sb.push_back(e);
        done = 1'b1;
      end else begin
        stalls++;
        tries++;
        if (tries > 200) begin
          chk("req_accept_timeout", 64'(tries), 64'd0);
          done = 1'b1;
        end
      end
    end
  endtask

  task automatic req_idle();
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while ((sb.size() != 0 || uq.size() != 0 || bus.rsp_valid) && n < 300) begin
      @(negedge clk);
      #2;
      n++;
    end
    chk(nm, 64'(n >= 300), 64'd0);
  endtask

  // execution unit stub: fixed one-cycle latency, optional hold and stray-beat modes
  initial begin
    bus.din_ready  = 1'b0;
    bus.dout_valid = 1'b0;
    bus.dout_rd    = '0;
    forever begin
      @(negedge clk);
      bus.din_ready = 1'b1;
      if (stub_bogus) begin
        bus.dout_valid = 1'b1;
        bus.dout_rd    = 32'hDEADBEEF;
      end else if (!stub_hold && uq.size() > 0 && uq[0].rdy <= cyc) begin
        bus.dout_valid = 1'b1;
        bus.dout_rd    = uq[0].rd;
      end else begin
        bus.dout_valid = 1'b0;
        bus.dout_rd    = '0;
      end
      #1;
      if (rst_n) begin
        if (bus.din_valid && bus.din_ready) begin
          uop_t u;
          u.rd  = unit_fn(bus.din_insn30, bus.din_insn29, bus.din_insn14,
                          bus.din_rs1, bus.din_rs2, bus.din_rs3);
          u.rdy = cyc + 1;
          uq.push_back(u);
        end
        if (bus.dout_valid && bus.dout_ready && !stub_bogus && uq.size() > 0) void'(uq.pop_front());
      end
    end
  end

  // response monitor: pops the scoreboard on every rsp handshake
  initial begin
    exp_t e;
    bus.rsp_ready = 1'b0;
    forever begin
      @(negedge clk);
      bus.rsp_ready = mon_rdy;
      #1;
      if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
        nbeats++;
        if (nbeats == mark + 1) first_cyc = cyc;
        last_cyc = cyc;
        if (sb.size() == 0) begin
          chk("rsp_unexpected", 64'(bus.rsp_tag), 64'hFFFF);
        end else begin
          e = sb.pop_front();
          chk("rsp_tag", 64'(bus.rsp_tag), 64'(e.tag));
          chk("rsp_rd", 64'(bus.rsp_rd), 64'(e.rd));
        end
      end
    end
  end

  initial begin
    int nb0, n;
    bus.req_valid = 1'b0;
    bus.req_insn  = '0;
    bus.req_rs1   = '0;
    bus.req_rs2   = '0;
    bus.req_rs3   = '0;
    bus.req_tag   = '0;

    #3;
    chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
    chk("rst_din_valid", 64'(bus.din_valid), 64'd0);
    chk("rst_dout_ready", 64'(bus.dout_ready), 64'd1);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_rsp_rd", 64'(bus.rsp_rd), 64'd0);
    #9 rst_n = 1'b1;

    // single ror, latency and din field mapping
    nb0 = nbeats;
    issue(0, 4'd3);
    req_idle();
    #2;
    chk("ror_din_valid", 64'(bus.din_valid), 64'd1);
    chk("ror_insn30", 64'(bus.din_insn30), 64'd1);
    chk("ror_insn29", 64'(bus.din_insn29), 64'd1);
    chk("ror_insn14", 64'(bus.din_insn14), 64'd1);
    chk("ror_insn3", 64'(bus.din_insn3), 64'd0);
    chk("ror_din_rs1", 64'(bus.din_rs1), 64'h1);
    @(negedge clk); #2;
    chk("ror_rsp_early", 64'(bus.rsp_valid), 64'd0);
    @(negedge clk); #2;
    chk("ror_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    chk("ror_rsp_tag", 64'(bus.rsp_tag), 64'd3);
    chk("ror_rsp_rd", 64'(bus.rsp_rd), 64'h80000000);
    drain("ror_drain");
    repeat (5) @(negedge clk);
    chk("ror_beats", 64'(nbeats - nb0), 64'd1);

    // back-to-back stream
    mark = nbeats;
    stalls = 0;
    for (int i = 0; i < NS; i++) issue(i % 8, TAGW'(i % 16));
    req_idle();
    drain("stream_drain");
    chk("stream_stalls", 64'(stalls), 64'd0);
    chk("stream_beats", 64'(nbeats - mark), 64'(NS));
    chk("stream_rate", 64'(last_cyc - first_cyc), 64'(NS - 1));

    // response backpressure fills the tag FIFO, then the issue register
    @(posedge clk); #2;
    mon_rdy = 1'b0;
    nb0 = nbeats;
    mark = nbeats;
    bp_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) issue(i, TAGW'(i + 8));
        req_idle();
        bp_done = 1'b1;
      end
    join_none
    repeat (20) @(negedge clk);
    #2;
    chk("bp_din_valid", 64'(bus.din_valid), 64'd0);
    chk("bp_req_ready", 64'(bus.req_ready), 64'd0);
    chk("bp_accepted", 64'(sb.size()), 64'd6);
    chk("bp_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    chk("bp_rsp_tag", 64'(bus.rsp_tag), 64'd8);
    mon_rdy = 1'b1;
    n = 0;
    while (!bp_done && n < 200) begin @(negedge clk); n++; end
    chk("bp_done_timeout", 64'(bp_done), 64'd1);
    drain("bp_drain");
    chk("bp_beats", 64'(nbeats - nb0), 64'd8);

    // unit never answers: watchdog behaviour depends on the build
    @(posedge clk); #2;
    stub_hold = 1'b1;
    issue(1, 4'd5);
    req_idle();
`ifdef RVB_ISSUE_TIMEOUT_EN
    @(posedge clk);
    repeat (9) @(posedge clk);
    #1;
    chk("tmo_err_before", 64'(err), 64'd0);
    @(posedge clk); #1;
    chk("tmo_err_at", 64'(err), 64'd1);
`else
    repeat (20) @(posedge clk);
    #1;
    chk("tmo_err_off", 64'(err), 64'd0);
`endif
    @(posedge clk); #2;
    stub_hold = 1'b0;
    drain("tmo_drain");

    // stray dout beat with nothing outstanding
    nb0 = nbeats;
    @(posedge clk); #2;
    stub_bogus = 1'b1;
    @(negedge clk); #2;
    chk("stray_dout_ready", 64'(bus.dout_ready), 64'd1);
    @(posedge clk); #2;
    stub_bogus = 1'b0;
    chk("stray_err", 64'(err), 64'd1);
    chk("stray_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    repeat (5) @(negedge clk);
    #2;
    chk("stray_err_sticky", 64'(err), 64'd1);
    chk("stray_beats", 64'(nbeats - nb0), 64'd0);

    // async reset with three ops outstanding
    @(posedge clk); #2;
    stub_hold = 1'b1;
    issue(2, 4'd1);
    issue(3, 4'd2);
    issue(4, 4'd4);
    req_idle();
    repeat (3) @(negedge clk);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("ar_req_ready", 64'(bus.req_ready), 64'd1);
    chk("ar_din_valid", 64'(bus.din_valid), 64'd0);
    chk("ar_dout_ready", 64'(bus.dout_ready), 64'd1);
    chk("ar_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("ar_err", 64'(err), 64'd0);
    chk("ar_rsp_tag", 64'(bus.rsp_tag), 64'd0);
    chk("ar_din_rs1", 64'(bus.din_rs1), 64'd0);
    sb.delete();
    uq.delete();
    @(negedge clk); #2;
    rst_n = 1'b1;
    stub_hold = 1'b0;
    nb0 = nbeats;
    issue(5, 4'd7);
    req_idle();
    drain("ar_drain");
    repeat (5) @(negedge clk);
    chk("ar_beats", 64'(nbeats - nb0), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
